// File: rtl/mips_rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// sequencer state encoding and the address-width helper.
package mips_rf_pkg;

  localparam int unsigned RF_DATA_W_DEF   = 32;
  localparam int unsigned RF_NUM_REGS_DEF = 32;

  typedef enum logic {
    INIT,
    READY
  } rf_state_t;

  // Address width for n entries, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rf_init_seq.sv
// Post-reset clear sequencer for the register file.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   init_we     : write strobe for the clear pass
//   init_addr   : entry currently being cleared
//   init_busy   : high until every entry has been cleared
module rf_init_seq
  import mips_rf_pkg::*;
#(
  parameter int unsigned NUM_REGS = RF_NUM_REGS_DEF,
  parameter int unsigned AW       = clog2_min1(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic          init_busy
);

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  rf_state_t     r_state;
  rf_state_t     w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    init_we     = 1'b0;
    init_addr   = r_cnt;
    init_busy   = 1'b0;
    case (r_state)
      INIT: begin
        init_we   = 1'b1;
        init_busy = 1'b1;
        if (r_cnt == LAST) begin
          w_state_nxt = READY;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with 1-cycle registered reads, optional
// hardwired-zero entry 0 and optional same-edge write-to-read bypass.
// Entries are cleared by rf_init_seq after every reset.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en/addr/data   : single write port (ignored while init_busy)
//   rd_en[p]          : per-port read strobe
//   rd_addr[p*AW+:AW] : packed read indices
//   rd_data[p*DW+:DW] : packed registered read data
//   init_busy         : high while the clear sequence runs
module reg_file_mp
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W_DEF,
  parameter int unsigned NUM_REGS = RF_NUM_REGS_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = clog2_min1(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     init_busy
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  logic              w_init_we;
  logic [AW-1:0]     w_init_addr;
  logic              w_init_busy;
  logic              w_wr_ok;
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  rf_init_seq #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_we   (w_init_we),
    .init_addr (w_init_addr),
    .init_busy (w_init_busy)
  );

  assign init_busy = w_init_busy;

  // User write is accepted only in READY, in range and not to the zero entry.
  assign w_wr_ok = wr_en && !w_init_busy
                && (32'(wr_addr) < NUM_REGS)
                && !((ZERO_REG != 0) && (wr_addr == '0));

  // The clear sequencer owns the write port while busy.
  assign w_mem_we    = w_init_we | w_wr_ok;
  assign w_mem_addr  = w_init_busy ? w_init_addr : wr_addr;
  assign w_mem_wdata = w_init_busy ? '0 : wr_data;

  // Array contents are not reset; the clear sequence initialises them.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]     w_ra;
    logic [DATA_W-1:0] w_rval;
    logic [DATA_W-1:0] r_rd;

    assign w_ra = rd_addr[p*AW +: AW];

    always_comb begin
      w_rval = '0;
      if ((32'(w_ra) < NUM_REGS) && !((ZERO_REG != 0) && (w_ra == '0))) begin
        // w_wr_ok already excludes the zero entry and out-of-range indices.
        if ((BYPASS != 0) && w_wr_ok && (wr_addr == w_ra)) begin
          w_rval = wr_data;
        end else begin
          w_rval = r_mem[w_ra];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd <= '0;
      end else if (!w_init_busy && rd_en[p]) begin
        r_rd <= w_rval;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = r_rd;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [2:0]  rd_en_c;
  logic [14:0] rd_addr_c;
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic [95:0] rd_c;
  logic        busy_a;
  logic        busy_b;
  logic        busy_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // A: defaults (zero reg, bypass). B: no zero reg, no bypass. C: 24 regs, 3 ports.
  reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_a), .init_busy(busy_a));

  reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_b), .init_busy(busy_b));

  reg_file_mp #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_c), .init_busy(busy_c));

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [2:0]  rec;
    logic [4:0]  rc0, rc1, rc2;
    logic [31:0] a0, a1, b0, b1, c0, c1, c2;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] a0, a1, b0, b1, c0, c1, c2;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[17];

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [2:0] rec, input logic [4:0] rc0, input logic [4:0] rc1, input logic [4:0] rc2,
    input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] b0, input logic [31:0] b1,
    input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra0 = ra0; v.ra1 = ra1;
    v.rec = rec; v.rc0 = rc0; v.rc1 = rc1; v.rc2 = rc2;
    v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1; v.c0 = c0; v.c1 = c1; v.c2 = c2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; rd_en_c = '0; rd_addr_c = '0;
  endtask

  // Drive one vector on the falling edge, queue its expectation, then check
  // the registered outputs just after the following rising edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    rd_en = v.re; rd_addr = {v.ra1, v.ra0};
    rd_en_c = v.rec; rd_addr_c = {v.rc2, v.rc1, v.rc0};
    e.idx = idx;
    e.a0 = v.a0; e.a1 = v.a1; e.b0 = v.b0; e.b1 = v.b1;
    e.c0 = v.c0; e.c1 = v.c1; e.c2 = v.c2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d.sb_empty", idx), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d.a0", e.idx), rd_a[31:0],  e.a0);
      chk($sformatf("v%0d.a1", e.idx), rd_a[63:32], e.a1);
      chk($sformatf("v%0d.b0", e.idx), rd_b[31:0],  e.b0);
      chk($sformatf("v%0d.b1", e.idx), rd_b[63:32], e.b1);
      chk($sformatf("v%0d.c0", e.idx), rd_c[31:0],  e.c0);
      chk($sformatf("v%0d.c1", e.idx), rd_c[63:32], e.c1);
      chk($sformatf("v%0d.c2", e.idx), rd_c[95:64], e.c2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   edges_a;
    int   edges_c;
    logic done_a;
    logic done_c;
    vec_t v;

    tbl[0]  = mk(1,  5, 32'hDEADBEEF, 2'b00,  0,  0, 3'b000,  0,  0,  0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[1]  = mk(0,  0, 32'h0,        2'b01,  5,  0, 3'b000,  0,  0,  0,
                 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[2]  = mk(1,  7, 32'h12345678, 2'b11,  7,  7, 3'b000,  0,  0,  0,
                 32'h12345678, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[3]  = mk(0,  0, 32'h0,        2'b11,  7,  7, 3'b000,  0,  0,  0,
                 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 32'h0);
    tbl[4]  = mk(1,  0, 32'hFFFFFFFF, 2'b00,  0,  0, 3'b000,  0,  0,  0,
                 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 32'h0);
    tbl[5]  = mk(0,  0, 32'h0,        2'b11,  0,  0, 3'b000,  0,  0,  0,
                 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    tbl[6]  = mk(1,  0, 32'h11,       2'b11,  0,  5, 3'b000,  0,  0,  0,
                 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    tbl[7]  = mk(0,  0, 32'h0,        2'b10,  0,  0, 3'b000,  0,  0,  0,
                 32'h0, 32'h0, 32'hFFFFFFFF, 32'h11, 32'h0, 32'h0, 32'h0);
    tbl[8]  = mk(1, 31, 32'hCAFEF00D, 2'b11, 31,  5, 3'b000,  0,  0,  0,
                 32'hCAFEF00D, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    tbl[9]  = mk(1, 31, 32'h55,       2'b11, 31, 31, 3'b000,  0,  0,  0,
                 32'h55, 32'h55, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
    tbl[10] = mk(0,  0, 32'h0,        2'b11,  3,  3, 3'b000,  0,  0,  0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[11] = mk(1,  3, 32'hA5A5,     2'b00,  0,  0, 3'b000,  0,  0,  0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[12] = mk(0,  0, 32'h0,        2'b11,  3, 31, 3'b000,  0,  0,  0,
                 32'hA5A5, 32'h55, 32'hA5A5, 32'h55, 32'h0, 32'h0, 32'h0);
    tbl[13] = mk(1, 23, 32'h2323,     2'b00,  0,  0, 3'b000,  0,  0,  0,
                 32'hA5A5, 32'h55, 32'hA5A5, 32'h55, 32'h0, 32'h0, 32'h0);
    tbl[14] = mk(0,  0, 32'h0,        2'b00,  0,  0, 3'b111, 30,  5, 23,
                 32'hA5A5, 32'h55, 32'hA5A5, 32'h55, 32'h0, 32'hDEADBEEF, 32'h2323);
    tbl[15] = mk(1, 30, 32'h77,       2'b00,  0,  0, 3'b111, 30, 23, 24,
                 32'hA5A5, 32'h55, 32'hA5A5, 32'h55, 32'h0, 32'h2323, 32'h0);
    tbl[16] = mk(0,  0, 32'h0,        2'b11, 30, 30, 3'b000,  0,  0,  0,
                 32'h77, 32'h77, 32'h77, 32'h77, 32'h0, 32'h2323, 32'h0);

    // Reset state
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rd_a_lo", rd_a[31:0], 32'h0);
    chk("rst.rd_a_hi", rd_a[63:32], 32'h0);
    chk("rst.rd_c_p2", rd_c[95:64], 32'h0);
    chk("rst.busy_a", {31'd0, busy_a}, 32'd1);
    chk("rst.busy_c", {31'd0, busy_c}, 32'd1);

    // First INIT, interrupted by a reset pulse after 20 cycles
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("init1.busy_k%0d", k), {31'd0, busy_a}, 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    #1;
    chk("midrst.busy_a", {31'd0, busy_a}, 32'd1);
    chk("midrst.rd_b_lo", rd_b[31:0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();

    // Full INIT from the release; writes and reads at cycle 10 must be ignored
    edges_a = 0; edges_c = 0; done_a = 1'b0; done_c = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 10) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA;
        rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
        rd_en_c = 3'b111; rd_addr_c = {5'd3, 5'd3, 5'd3};
      end else begin
        drive_idle();
      end
      @(posedge clk);
      #1;
      if (!busy_a && !done_a) begin edges_a = k; done_a = 1'b1; end
      if (!busy_c && !done_c) begin edges_c = k; done_c = 1'b1; end
      if (k == 10 || k == 11) begin
        chk($sformatf("init.rd_a_k%0d", k), rd_a[31:0] | rd_a[63:32], 32'h0);
        chk($sformatf("init.rd_c_k%0d", k), rd_c[31:0] | rd_c[63:32] | rd_c[95:64], 32'h0);
      end
      if (done_a && done_c) break;
      @(negedge clk);
    end
    chk("init.len_a", edges_a, 32);
    chk("init.len_c", edges_c, 24);
    chk("init.busy_b_done", {31'd0, busy_b}, 32'd0);

    // Every entry reads zero after the clear pass
    for (int i = 0; i < 32; i += 2) begin
      v = mk(0, 0, 32'h0, 2'b11, 5'(i), 5'(i + 1), 3'b111, 5'(i), 5'(i + 1), 5'(i),
             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      apply(v, 100 + i);
    end

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i], i);
    end

    @(negedge clk);
    drive_idle();
    chk("sb.drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
